// File: rtl/ml_acc_intr_pkg.sv
// rtl/ml_acc_intr_pkg.sv - register map, FSM states and helpers for ml_acc_intr_ctrl
package ml_acc_intr_pkg;

   localparam logic [4:0] ADDR_GIE  = 5'h00;
   localparam logic [4:0] ADDR_IER  = 5'h04;
   localparam logic [4:0] ADDR_STS  = 5'h08;
   localparam logic [4:0] ADDR_ACK  = 5'h0C;
   localparam logic [4:0] ADDR_PEND = 5'h10;
   localparam logic [4:0] ADDR_MODE = 5'h14;
   localparam logic [4:0] ADDR_RAW  = 5'h18;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic {W_IDLE, W_RESP} wr_state_e;
   typedef enum logic {R_IDLE, R_DATA} rd_state_e;

   function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
      logic [31:0] mask;
      for (int b = 0; b < 4; b++) begin
         mask[8*b +: 8] = {8{strb[b]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/ml_acc_intr_ctrl_if.sv
// rtl/ml_acc_intr_ctrl_if.sv - AXI4-Lite register bus of the interrupt controller
interface ml_acc_intr_ctrl_if #(
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/ml_acc_intr_src.sv
// rtl/ml_acc_intr_src.sv - per-source capture: edge history, STS bit and PEND output
module ml_acc_intr_src (
   input  logic clk,
   input  logic rst_n,
   input  logic src_i,
   input  logic mode_i,
   input  logic ack_i,
   input  logic ier_i,
   output logic sts_o,
   output logic pend_o
);
   logic prev_q;
   logic sts_q, sts_d;
   logic set;

   // mode_i=1 captures rising edges only; mode_i=0 captures every high cycle
   assign set   = src_i & (~mode_i | ~prev_q);
   assign sts_d = set | (sts_q & ~ack_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b0;
         sts_q  <= 1'b0;
      end else begin
         prev_q <= src_i;
         sts_q  <= sts_d;
      end
   end

   assign sts_o  = sts_q;
   assign pend_o = sts_q & ier_i;
endmodule

// File: rtl/ml_acc_intr_ctrl.sv
// rtl/ml_acc_intr_ctrl.sv - AXI4-Lite interrupt controller for up to 32 same-clock sources
module ml_acc_intr_ctrl
   import ml_acc_intr_pkg::*;
#(
   parameter int                       C_NUM_OF_INTR      = 4,
   parameter int                       C_S_AXI_ADDR_WIDTH = 5,
   parameter bit                       C_IRQ_ACTIVE_STATE = 1'b1,
   parameter int                       C_IRQ_PULSE_CYCLES = 0,
   parameter logic [C_NUM_OF_INTR-1:0] C_MODE_RESET       = '1
) (
   input  logic                     ACLK,
   input  logic                     ARESETN,
   input  logic [C_NUM_OF_INTR-1:0] intr_src,
   output logic                     irq,
   ml_acc_intr_ctrl_if.slave        s_axi_intr
);
   localparam int N  = C_NUM_OF_INTR;
   localparam int CW = (C_IRQ_PULSE_CYCLES > 0) ? $clog2(C_IRQ_PULSE_CYCLES + 1) : 1;

   wr_state_e w_state_q, w_state_d;
   rd_state_e r_state_q, r_state_d;
   logic awready_q, awready_d, bvalid_q, bvalid_d;
   logic arready_q, arready_d, rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d, rd_word, wmask;
   logic gie_q, gie_d;
   logic [N-1:0] ier_q, ier_d, mode_q, mode_d, ack_clr, sts, pend;
   logic [CW-1:0] cnt_q, cnt_d;
   logic req_q, irq_req, irq_act_q, irq_act_d;
   logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
   logic [4:0] waddr_w, raddr_w;
   logic wr_fire, rd_fire, unused_bits;

   assign awaddr      = s_axi_intr.awaddr;
   assign araddr      = s_axi_intr.araddr;
   assign waddr_w     = {awaddr[4:2], 2'b00};
   assign raddr_w     = {araddr[4:2], 2'b00};
   assign wr_fire     = awready_q & s_axi_intr.awvalid & s_axi_intr.wvalid;
   assign rd_fire     = arready_q & s_axi_intr.arvalid;
   assign wmask       = strb_to_mask(s_axi_intr.wstrb);
   assign unused_bits = ^{awaddr, araddr, s_axi_intr.wdata, wmask};

   for (genvar i = 0; i < N; i++) begin : g_src
      ml_acc_intr_src u_src (
         .clk    (ACLK),
         .rst_n  (ARESETN),
         .src_i  (intr_src[i]),
         .mode_i (mode_q[i]),
         .ack_i  (ack_clr[i]),
         .ier_i  (ier_q[i]),
         .sts_o  (sts[i]),
         .pend_o (pend[i])
      );
   end

   always_comb begin
      gie_d   = gie_q;
      ier_d   = ier_q;
      mode_d  = mode_q;
      ack_clr = '0;
      if (wr_fire) begin
         case (waddr_w)
            ADDR_GIE:  if (wmask[0]) gie_d = s_axi_intr.wdata[0];
            ADDR_IER:  ier_d   = (ier_q & ~wmask[N-1:0]) | (s_axi_intr.wdata[N-1:0] & wmask[N-1:0]);
            ADDR_ACK:  ack_clr = s_axi_intr.wdata[N-1:0] & wmask[N-1:0];
            ADDR_MODE: mode_d  = (mode_q & ~wmask[N-1:0]) | (s_axi_intr.wdata[N-1:0] & wmask[N-1:0]);
            default:   ;
         endcase
      end
   end

   always_comb begin
      rd_word = '0;
      case (raddr_w)
         ADDR_GIE:  rd_word[0]     = gie_q;
         ADDR_IER:  rd_word[N-1:0] = ier_q;
         ADDR_STS:  rd_word[N-1:0] = sts;
         ADDR_PEND: rd_word[N-1:0] = pend;
         ADDR_MODE: rd_word[N-1:0] = mode_q;
         ADDR_RAW:  rd_word[N-1:0] = intr_src;
         default:   ;
      endcase
   end

   // Pulse mode retriggers on each rising edge of irq_req, reloading a running pulse
   assign irq_req = gie_q & (|pend);

   always_comb begin
      cnt_d     = cnt_q;
      irq_act_d = irq_req;
      if (C_IRQ_PULSE_CYCLES > 0) begin
         if (irq_req && !req_q) cnt_d = CW'(C_IRQ_PULSE_CYCLES);
         else if (cnt_q != '0)  cnt_d = cnt_q - CW'(1);
         irq_act_d = (cnt_d != '0);
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      awready_d = 1'b0;
      bvalid_d  = bvalid_q;
      case (w_state_q)
         W_IDLE: begin
            if (wr_fire) begin
               w_state_d = W_RESP;
               bvalid_d  = 1'b1;
            end else if (s_axi_intr.awvalid && s_axi_intr.wvalid) begin
               awready_d = 1'b1;
            end
         end
         W_RESP: begin
            if (s_axi_intr.bready) begin
               w_state_d = W_IDLE;
               bvalid_d  = 1'b0;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      arready_d = 1'b0;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      case (r_state_q)
         R_IDLE: begin
            if (rd_fire) begin
               r_state_d = R_DATA;
               rvalid_d  = 1'b1;
               rdata_d   = rd_word;
            end else if (s_axi_intr.arvalid) begin
               arready_d = 1'b1;
            end
         end
         R_DATA: begin
            if (s_axi_intr.rready) begin
               r_state_d = R_IDLE;
               rvalid_d  = 1'b0;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         gie_q     <= 1'b0;
         ier_q     <= '0;
         mode_q    <= C_MODE_RESET;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         irq_act_q <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         awready_q <= awready_d;
         bvalid_q  <= bvalid_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         gie_q     <= gie_d;
         ier_q     <= ier_d;
         mode_q    <= mode_d;
         cnt_q     <= cnt_d;
         req_q     <= irq_req;
         irq_act_q <= irq_act_d;
      end
   end

   assign irq                = irq_act_q ^ ~C_IRQ_ACTIVE_STATE;
   assign s_axi_intr.awready = awready_q;
   assign s_axi_intr.wready  = awready_q;
   assign s_axi_intr.bvalid  = bvalid_q;
   assign s_axi_intr.bresp   = RESP_OKAY;
   assign s_axi_intr.arready = arready_q;
   assign s_axi_intr.rvalid  = rvalid_q;
   assign s_axi_intr.rdata   = rdata_q;
   assign s_axi_intr.rresp   = RESP_OKAY;
endmodule
